mips_dbg_loader: RTL and testbench

MIPS_DBG_LOADER -- requirements
Module: mips_dbg_loader

---
 rtl/mips_dbg_loader_pkg.sv | 37 +++
 rtl/mips_dbg_loader_timeout_ctr.sv | 27 ++
 rtl/mips_dbg_loader.sv | 172 +++++++++++++++++
 tb/tb_mips_dbg_loader.sv | 335 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_dbg_loader_pkg.sv
// Shared definitions for the MIPS debug loader.
//   - command opcodes carried on cmd_op
//   - loader FSM state encoding
//   - HLT opcode of the target processor (top 6 bits of the halt instruction)
//   - length decode helpers: a zero length field means "full block"
package mips_dbg_loader_pkg;

  typedef enum logic [1:0] {
    OP_NOP  = 2'd0,
    OP_LOAD = 2'd1,
    OP_RUN  = 2'd2,
    OP_DUMP = 2'd3
  } cmd_op_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_START,
    ST_RUN,
    ST_DUMP_ADDR,
    ST_DUMP_OUT
  } state_e;

  localparam logic [5:0] HLT_OPCODE = 6'h3f;

  // Remaining-count width: must hold 64 (LOAD with len field 0).
  localparam int REM_W = 7;

  function automatic logic [REM_W-1:0] load_len(input logic [5:0] len);
    return (len == 6'd0) ? 7'd64 : {1'b0, len};
  endfunction

  function automatic logic [REM_W-1:0] dump_len(input logic [5:0] len);
    return (len == 6'd0) ? 7'd32 : {1'b0, len};
  endfunction

endpackage

// File: rtl/mips_dbg_loader_timeout_ctr.sv
// Run-timeout counter for the debug loader.
//   clk_i  : clock
//   rst_i  : synchronous active-high reset (counter to 0)
//   load_i : restart count at 0 (takes priority over en_i)
//   en_i   : advance count by one
//   tc_o   : terminal count, high while the count is all-ones
module dbg_timeout_ctr #(
  parameter int W = 16
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic load_i,
  input  logic en_i,
  output logic tc_o
);

  logic [W-1:0] cnt_q;

  always_ff @(posedge clk_i) begin
    if (rst_i)       cnt_q <= '0;
    else if (load_i) cnt_q <= '0;
    else if (en_i)   cnt_q <= cnt_q + 1'b1;
  end

  assign tc_o = &cnt_q;

endmodule

// File: rtl/mips_dbg_loader.sv
// Debug loader for a small MIPS core: loads program words into instruction
// memory, starts the core and waits for HLT (with timeout), and dumps a range
// of the register file over a ready/valid stream.
//
// Ports
//   clk1, rst                 : clock, synchronous active-high reset
//   cmd_valid/ready/op/addr/len : command channel (NOP/LOAD/RUN/DUMP)
//   wr_valid/ready/data       : program-word stream consumed during LOAD
//   mem_we/addr/wdata         : processor memory write port
//   cpu_hold, cpu_start       : processor halt request, one-cycle start pulse
//   cpu_halted                : processor retired HLT
//   reg_raddr/reg_rdata       : register-file read port
//   rd_valid/ready/data       : register-dump stream
//   busy, done, timeout       : status (done/timeout are one-cycle pulses)
module mips_dbg_loader
  import mips_dbg_loader_pkg::*;
#(
  parameter int ADDR_W = 10,
  parameter int TMO_W  = 16
) (
  input  logic              clk1,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [1:0]        cmd_op,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [5:0]        cmd_len,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [31:0]       wr_data,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              cpu_hold,
  output logic              cpu_start,
  input  logic              cpu_halted,
  output logic [4:0]        reg_raddr,
  input  logic [31:0]       reg_rdata,
  output logic              rd_valid,
  input  logic              rd_ready,
  output logic [31:0]       rd_data,
  output logic              busy,
  output logic              done,
  output logic              timeout
);

  state_e            state_q;
  logic [ADDR_W-1:0] addr_q;
  logic [4:0]        raddr_q;
  logic [REM_W-1:0]  rem_q;
  logic [31:0]       rd_data_q;
  logic              done_q;
  logic              timeout_q;
  logic              tmo_tc;

  logic cmd_hs, wr_hs, rd_hs;

  // Handshake-ready outputs are masked by rst so nothing is accepted (and no
  // memory write issued) in a reset cycle, whatever state the FSM was in.
  assign cmd_ready = (state_q == ST_IDLE) && !rst;
  assign wr_ready  = (state_q == ST_LOAD) && !rst;
  assign rd_valid  = (state_q == ST_DUMP_OUT);
  assign cpu_start = (state_q == ST_START);
  assign cpu_hold  = !((state_q == ST_START) || (state_q == ST_RUN));
  assign busy      = (state_q != ST_IDLE);

  assign cmd_hs = cmd_valid && cmd_ready;
  assign wr_hs  = wr_valid && wr_ready;
  assign rd_hs  = rd_valid && rd_ready;

  // The write goes out in the handshake cycle itself; mem_addr points at the
  // slot the current word lands in.
  assign mem_we    = wr_hs;
  assign mem_addr  = addr_q;
  assign mem_wdata = wr_data;

  assign reg_raddr = raddr_q;
  assign rd_data   = rd_data_q;
  assign done      = done_q;
  assign timeout   = timeout_q;

  // Counter restarts while in START so the first RUN cycle sees a count of 0.
  dbg_timeout_ctr #(.W(TMO_W)) u_tmo (
    .clk_i  (clk1),
    .rst_i  (rst),
    .load_i (state_q == ST_START),
    .en_i   (state_q == ST_RUN),
    .tc_o   (tmo_tc)
  );

  always_ff @(posedge clk1) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      addr_q    <= '0;
      raddr_q   <= '0;
      rem_q     <= '0;
      rd_data_q <= '0;
      done_q    <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      done_q    <= 1'b0;
      timeout_q <= 1'b0;
      unique case (state_q)
        ST_IDLE: begin
          if (cmd_hs) begin
            unique case (cmd_op_e'(cmd_op))
              OP_LOAD: begin
                addr_q  <= cmd_addr;
                rem_q   <= load_len(cmd_len);
                state_q <= ST_LOAD;
              end
              OP_RUN:  state_q <= ST_START;
              OP_DUMP: begin
                raddr_q <= cmd_addr[4:0];
                rem_q   <= dump_len(cmd_len);
                state_q <= ST_DUMP_ADDR;
              end
              OP_NOP:  ;
            endcase
          end
        end

        ST_LOAD: begin
          if (wr_hs) begin
            addr_q <= addr_q + 1'b1;   // wraps modulo 2^ADDR_W
            rem_q  <= rem_q - 1'b1;
            if (rem_q == 7'd1) begin
              done_q  <= 1'b1;
              state_q <= ST_IDLE;
            end
          end
        end

        ST_START: state_q <= ST_RUN;

        ST_RUN: begin
          // Halt is checked first so it wins over a simultaneous timeout.
          if (cpu_halted) begin
            done_q  <= 1'b1;
            state_q <= ST_IDLE;
          end else if (tmo_tc) begin
            timeout_q <= 1'b1;
            state_q   <= ST_IDLE;
          end
        end

        // reg_raddr has been stable since the edge entering this state, so the
        // read data is valid by the edge leaving it.
        ST_DUMP_ADDR: begin
          rd_data_q <= reg_rdata;
          state_q   <= ST_DUMP_OUT;
        end

        ST_DUMP_OUT: begin
          if (rd_hs) begin
            if (rem_q == 7'd1) begin
              done_q  <= 1'b1;
              state_q <= ST_IDLE;
            end else begin
              raddr_q <= raddr_q + 5'd1;   // wraps 31 -> 0
              rem_q   <= rem_q - 1'b1;
              state_q <= ST_DUMP_ADDR;
            end
          end
        end

        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mips_dbg_loader.sv
// Directed bench for mips_dbg_loader. Inputs change on the falling edge,
// outputs are sampled on the falling edge (or #1 after it for same-cycle
// combinational paths). A second instance with TMO_W=4 covers the timeout.
module tb_mips_dbg_loader;
  import mips_dbg_loader_pkg::*;

  localparam int AW = 10;

  logic clk1 = 1'b0;
  always #5 clk1 = ~clk1;

  logic          rst, cmd_valid, t_cmd_valid, wr_valid, cpu_halted, rd_ready;
  logic [1:0]    cmd_op;
  logic [AW-1:0] cmd_addr;
  logic [5:0]    cmd_len;
  logic [31:0]   wr_data, reg_rdata;

  logic          cmd_ready, wr_ready, mem_we, cpu_hold, cpu_start, rd_valid, busy, done, timeout;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata, rd_data;
  logic [4:0]    reg_raddr;

  logic          t_cmd_ready, t_wr_ready, t_mem_we, t_cpu_hold, t_cpu_start, t_rd_valid, t_busy, t_done, t_timeout;
  logic [AW-1:0] t_mem_addr;
  logic [31:0]   t_mem_wdata, t_rd_data;
  logic [4:0]    t_reg_raddr;

  mips_dbg_loader #(.ADDR_W(AW), .TMO_W(16)) dut (
    .clk1(clk1), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_addr(cmd_addr), .cmd_len(cmd_len), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .wr_data(wr_data), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .cpu_hold(cpu_hold), .cpu_start(cpu_start), .cpu_halted(cpu_halted), .reg_raddr(reg_raddr),
    .reg_rdata(reg_rdata), .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data),
    .busy(busy), .done(done), .timeout(timeout));

  mips_dbg_loader #(.ADDR_W(AW), .TMO_W(4)) dut_t (
    .clk1(clk1), .rst(rst), .cmd_valid(t_cmd_valid), .cmd_ready(t_cmd_ready), .cmd_op(cmd_op),
    .cmd_addr(cmd_addr), .cmd_len(cmd_len), .wr_valid(wr_valid), .wr_ready(t_wr_ready),
    .wr_data(wr_data), .mem_we(t_mem_we), .mem_addr(t_mem_addr), .mem_wdata(t_mem_wdata),
    .cpu_hold(t_cpu_hold), .cpu_start(t_cpu_start), .cpu_halted(cpu_halted), .reg_raddr(t_reg_raddr),
    .reg_rdata(reg_rdata), .rd_valid(t_rd_valid), .rd_ready(rd_ready), .rd_data(t_rd_data),
    .busy(t_busy), .done(t_done), .timeout(t_timeout));

  // Register-file model: asynchronous read of the addressed register.
  logic [31:0] rf [32];
  assign reg_rdata = rf[reg_raddr];

  logic [31:0] prog [9];

  int checks = 0, failures = 0;
  int we_cnt = 0, done_cnt = 0, tmo_cnt = 0, start_cnt = 0, cyc = 0;
  logic [AW-1:0] wa [$];
  logic [31:0]   wd [$];
  logic [31:0]   rd_log [$];
  int            rd_cyc [$];

  always @(posedge clk1) begin
    if (mem_we) begin we_cnt++; wa.push_back(mem_addr); wd.push_back(mem_wdata); end
    if (done) done_cnt++;
    if (timeout) tmo_cnt++;
    if (cpu_start) start_cnt++;
    if (rd_valid && rd_ready) begin rd_log.push_back(rd_data); rd_cyc.push_back(cyc); end
    cyc++;
  end

  task automatic cmd1(input logic [1:0] op, input logic [AW-1:0] a, input logic [5:0] l);
    @(negedge clk1);
    cmd_valid = 1'b1; cmd_op = op; cmd_addr = a; cmd_len = l;
    @(negedge clk1);
    cmd_valid = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    @(negedge clk1); @(negedge clk1);
    checks++;
    if ({cmd_ready, wr_ready, mem_we, cpu_start, rd_valid, done, timeout, busy} !== 8'h00) begin
      failures++; $display("FAIL reset_ctrl: got %b expected 00000000",
        {cmd_ready, wr_ready, mem_we, cpu_start, rd_valid, done, timeout, busy});
    end
    checks++;
    if (cpu_hold !== 1'b1) begin failures++; $display("FAIL reset_hold: got %b expected 1", cpu_hold); end
    checks++;
    if ({mem_addr, reg_raddr, rd_data} !== '0) begin
      failures++; $display("FAIL reset_regs: got %0h/%0h/%0h expected 0", mem_addr, reg_raddr, rd_data);
    end
    checks++;
    if ({t_cmd_ready, t_wr_ready, t_mem_we, t_cpu_start, t_rd_valid, t_done, t_timeout, t_busy,
         t_mem_addr, t_reg_raddr, t_rd_data, ~t_cpu_hold} !== '0 || t_mem_wdata !== wr_data) begin
      failures++; $display("FAIL reset_tmo_inst: got hold=%b busy=%b expected hold=1 busy=0", t_cpu_hold, t_busy);
    end
    rst = 1'b0;
    @(negedge clk1);
    checks++;
    if (cmd_ready !== 1'b1 || busy !== 1'b0) begin
      failures++; $display("FAIL reset_release: got ready=%b busy=%b expected 1/0", cmd_ready, busy);
    end
  endtask

  task automatic test_nop;
    int d0 = done_cnt;
    cpu_halted = 1'b1;               // ignored outside RUN
    cmd1(OP_NOP, '0, 6'd0);
    repeat (3) @(negedge clk1);
    checks++;
    if (cmd_ready !== 1'b1 || busy !== 1'b0 || done_cnt != d0 || cpu_hold !== 1'b1) begin
      failures++; $display("FAIL nop: got ready=%b busy=%b dones=%0d expected 1/0/0", cmd_ready, busy, done_cnt - d0);
    end
    cpu_halted = 1'b0;
  endtask

  task automatic test_load;
    int w0 = we_cnt;
    int bad = 0;
    wa.delete(); wd.delete();
    cmd1(OP_LOAD, '0, 6'd9);
    for (int i = 0; i < 9; i++) begin
      if (i == 4) begin
        wr_valid = 1'b0; #1;
        checks++;
        if (mem_we !== 1'b0) begin failures++; $display("FAIL load_gap_we: got %b expected 0", mem_we); end
        @(negedge clk1);
      end
      wr_valid = 1'b1; wr_data = prog[i]; #1;
      checks++;
      if (mem_we !== 1'b1 || mem_addr !== AW'(i) || mem_wdata !== prog[i]) begin
        failures++; $display("FAIL load_word%0d: got we=%b addr=%0d data=%h expected 1/%0d/%h",
          i, mem_we, mem_addr, mem_wdata, i, prog[i]);
      end
      @(negedge clk1);
    end
    wr_valid = 1'b0; #1;
    checks++;
    if (done !== 1'b1 || wr_ready !== 1'b0) begin
      failures++; $display("FAIL load_done: got done=%b wr_ready=%b expected 1/0", done, wr_ready);
    end
    for (int i = 0; i < 9; i++) if (i >= wa.size() || wa[i] !== AW'(i) || wd[i] !== prog[i]) bad++;
    checks++;
    if (we_cnt - w0 != 9 || bad != 0) begin
      failures++; $display("FAIL load_log: got %0d writes (%0d wrong) expected 9 (0 wrong)", we_cnt - w0, bad);
    end
    @(negedge clk1);
    checks++;
    if (done !== 1'b0) begin failures++; $display("FAIL load_done_pulse: got %b expected 0", done); end
  endtask

  task automatic test_run;
    int s0 = start_cnt, t0 = tmo_cnt;
    int bad = 0;
    cmd1(OP_RUN, '0, 6'd0);
    #1;
    checks++;
    if (cpu_start !== 1'b1 || cpu_hold !== 1'b0) begin
      failures++; $display("FAIL run_start: got start=%b hold=%b expected 1/0", cpu_start, cpu_hold);
    end
    repeat (40) begin
      @(negedge clk1);
      if (cpu_hold !== 1'b0 || cpu_start !== 1'b0 || done !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0) begin failures++; $display("FAIL run_wait: got %0d bad cycles expected 0", bad); end
    cpu_halted = 1'b1;
    @(negedge clk1);
    cpu_halted = 1'b0;
    checks++;
    if (done !== 1'b1 || timeout !== 1'b0 || cpu_hold !== 1'b1) begin
      failures++; $display("FAIL run_done: got done=%b tmo=%b hold=%b expected 1/0/1", done, timeout, cpu_hold);
    end
    checks++;
    if (start_cnt - s0 != 1) begin failures++; $display("FAIL run_start_len: got %0d expected 1", start_cnt - s0); end
    @(negedge clk1);
    checks++;
    if (done !== 1'b0 || tmo_cnt != t0) begin
      failures++; $display("FAIL run_after: got done=%b tmos=%0d expected 0/0", done, tmo_cnt - t0);
    end
  endtask

  task automatic test_timeout;
    int bad = 0;
    @(negedge clk1);
    t_cmd_valid = 1'b1; cmd_op = OP_RUN;
    @(negedge clk1);
    t_cmd_valid = 1'b0;
    checks++;
    if (t_cpu_start !== 1'b1) begin failures++; $display("FAIL tmo_start: got %b expected 1", t_cpu_start); end
    // RUN entered at the next edge; terminal count reached 16 edges later.
    for (int k = 2; k <= 17; k++) begin
      @(negedge clk1);
      if (t_timeout !== 1'b0 || t_done !== 1'b0 || t_cpu_hold !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0) begin failures++; $display("FAIL tmo_early: got %0d bad cycles expected 0", bad); end
    @(negedge clk1);
    checks++;
    if (t_timeout !== 1'b1 || t_done !== 1'b0 || t_cpu_hold !== 1'b1 || t_busy !== 1'b0) begin
      failures++; $display("FAIL tmo_fire: got tmo=%b done=%b hold=%b busy=%b expected 1/0/1/0",
        t_timeout, t_done, t_cpu_hold, t_busy);
    end
    @(negedge clk1);
    checks++;
    if (t_timeout !== 1'b0) begin failures++; $display("FAIL tmo_pulse: got %b expected 0", t_timeout); end
  endtask

  task automatic test_dump;
    logic [31:0] exp [6];
    logic pv, pr, r;
    logic [31:0] pd;
    int stalls = 0, bad = 0, fin = 0;
    exp[0] = 32'd0; exp[1] = 32'd10; exp[2] = 32'd20; exp[3] = 32'd25; exp[4] = 32'd30; exp[5] = 32'd55;
    for (int i = 0; i < 6; i++) rf[i] = exp[i];
    rd_log.delete();
    rd_ready = 1'b1;
    cmd1(OP_DUMP, '0, 6'd6);
    pv = 1'b0; pr = 1'b1; pd = '0; r = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk1);
      if (done === 1'b1) begin fin = 1; break; end
      if (pv && !pr) begin
        stalls++;
        if (rd_valid !== 1'b1 || rd_data !== pd) bad++;
      end
      rd_ready = r; r = ~r;
      pv = rd_valid; pr = rd_ready; pd = rd_data;
    end
    rd_ready = 1'b0;
    checks++;
    if (fin != 1) begin failures++; $display("FAIL dump_done: got no done expected done within 40 cycles"); end
    checks++;
    if (stalls == 0 || bad != 0) begin
      failures++; $display("FAIL dump_stable: got %0d stalls %0d unstable expected >0 stalls 0 unstable", stalls, bad);
    end
    checks++;
    if (rd_log.size() != 6) begin failures++; $display("FAIL dump_count: got %0d expected 6", rd_log.size()); end
    for (int i = 0; i < 6 && i < rd_log.size(); i++) begin
      checks++;
      if (rd_log[i] !== exp[i]) begin failures++; $display("FAIL dump_r%0d: got %0d expected %0d", i, rd_log[i], exp[i]); end
    end
  endtask

  task automatic test_dump_wrap;
    int fin = 0;
    rd_log.delete(); rd_cyc.delete();
    rd_ready = 1'b1;
    cmd1(OP_DUMP, AW'(30), 6'd3);
    for (int k = 0; k < 20; k++) begin
      @(negedge clk1);
      if (done === 1'b1) begin fin = 1; break; end
    end
    rd_ready = 1'b0;
    checks++;
    if (fin != 1 || rd_log.size() != 3) begin
      failures++; $display("FAIL dwrap_count: got %0d items expected 3", rd_log.size());
    end else begin
      checks++;
      if (rd_log[0] !== 32'hdead001e || rd_log[1] !== 32'hdead001f || rd_log[2] !== 32'd0) begin
        failures++; $display("FAIL dwrap_data: got %h %h %h expected dead001e dead001f 00000000",
          rd_log[0], rd_log[1], rd_log[2]);
      end
      checks++;
      if (rd_cyc[1] - rd_cyc[0] != 2 || rd_cyc[2] - rd_cyc[1] != 2) begin
        failures++; $display("FAIL dwrap_rate: got gaps %0d %0d expected 2 2", rd_cyc[1] - rd_cyc[0], rd_cyc[2] - rd_cyc[1]);
      end
    end
  endtask

  task automatic test_load_wrap;
    int d0 = done_cnt;
    wa.delete(); wd.delete();
    cmd1(OP_LOAD, AW'(1022), 6'd4);
    for (int i = 0; i < 4; i++) begin
      wr_valid = 1'b1; wr_data = 32'ha000 + i;
      @(negedge clk1);
    end
    wr_valid = 1'b0;
    checks++;
    if (wa.size() != 4 || done_cnt - d0 != 1 || done !== 1'b1) begin
      failures++; $display("FAIL lwrap_count: got %0d writes done=%b expected 4/1", wa.size(), done);
    end else begin
      checks++;
      if (wa[0] !== 10'd1022 || wa[1] !== 10'd1023 || wa[2] !== 10'd0 || wa[3] !== 10'd1) begin
        failures++; $display("FAIL lwrap_addr: got %0d %0d %0d %0d expected 1022 1023 0 1", wa[0], wa[1], wa[2], wa[3]);
      end
    end
  endtask

  task automatic test_reset_mid_load;
    int w0, d0;
    cmd1(OP_LOAD, AW'(16), 6'd9);
    w0 = we_cnt; d0 = done_cnt;
    for (int i = 0; i < 3; i++) begin
      wr_valid = 1'b1; wr_data = prog[i];
      @(negedge clk1);
    end
    wr_data = prog[3]; rst = 1'b1; #1;
    checks++;
    if (mem_we !== 1'b0) begin failures++; $display("FAIL rstload_we: got %b expected 0", mem_we); end
    @(negedge clk1);
    rst = 1'b0; #1;
    checks++;
    if (cmd_ready !== 1'b1 || wr_ready !== 1'b0 || mem_we !== 1'b0 || mem_addr !== '0) begin
      failures++; $display("FAIL rstload_release: got ready=%b wr_ready=%b we=%b addr=%0d expected 1/0/0/0",
        cmd_ready, wr_ready, mem_we, mem_addr);
    end
    repeat (2) @(negedge clk1);
    wr_valid = 1'b0;
    checks++;
    if (we_cnt - w0 != 3 || done_cnt != d0) begin
      failures++; $display("FAIL rstload_abort: got %0d writes %0d dones expected 3/0", we_cnt - w0, done_cnt - d0);
    end
  endtask

  initial begin
    rst = 1'b1; cmd_valid = 1'b0; t_cmd_valid = 1'b0; wr_valid = 1'b0; cpu_halted = 1'b0; rd_ready = 1'b0;
    cmd_op = 2'd0; cmd_addr = '0; cmd_len = '0; wr_data = '0;
    for (int i = 0; i < 32; i++) rf[i] = 32'hdead0000 | i;
    // ADDI R1,R0,10 / ADDI R2,R0,20 / ADDI R3,R0,25 / OR x2 / ADD R4,R1,R2 / OR / ADD R5,R4,R3 / HLT
    prog[0] = 32'h2801000a; prog[1] = 32'h28020014; prog[2] = 32'h28030019;
    prog[3] = 32'h0ce77800; prog[4] = 32'h0ce77800; prog[5] = 32'h00222000;
    prog[6] = 32'h0ce77800; prog[7] = 32'h00832800; prog[8] = {HLT_OPCODE, 26'd0};

    test_reset();
    test_nop();
    test_load();
    test_run();
    test_timeout();
    test_dump();
    test_dump_wrap();
    test_load_wrap();
    test_reset_mid_load();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
